// File: rtl/dmgplus_pkg.sv
// Shared types and constants for the DMG+ cartridge-side logic.
// Also defines the cycle-parameter range check used at elaboration.
`ifndef DMGPLUS_PKG_SV
`define DMGPLUS_PKG_SV

`define DMGPLUS_CYC_IN_RANGE(p) (((p) >= 1) && ((p) <= 15))

package dmgplus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } cart_rd_state_t;

  localparam logic [15:0] CART_CS_LO = 16'hA000;
  localparam logic [15:0] CART_CS_HI = 16'hFDFF;

  // /CS covers external RAM through echo space; ROM space never selects it.
  function automatic logic cart_cs_range(input logic [15:0] addr);
    return (addr >= CART_CS_LO) && (addr <= CART_CS_HI);
  endfunction

endpackage

`endif

// File: rtl/dmgplus_cart_rd_if.sv
// Single-byte ROM request bus between header readers (master) and the
// cartridge read engine (slave).
interface dmgplus_cart_rd_if;
  logic [15:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_data;
  logic        rom_bsy;

  modport master (
    output rom_addr,
    output rom_rd,
    input  rom_data,
    input  rom_bsy
  );

  modport slave (
    input  rom_addr,
    input  rom_rd,
    output rom_data,
    output rom_bsy
  );
endinterface

// File: rtl/dmgplus_cart_rd.sv
// Runs one timed read cycle on the DMG cartridge bus per rom_rd request.
// One 4-bit down-counter times the setup, strobe and hold phases.
module dmgplus_cart_rd
  import dmgplus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic               clk_8m,
  input  logic               rst_n,
  dmgplus_cart_rd_if.slave   rom,
  output logic [15:0]        cart_a,
  input  logic [7:0]         cart_d,
  output logic               cart_rd_n,
  output logic               cart_wr_n,
  output logic               cart_cs_n
);

  generate
    if (!(`DMGPLUS_CYC_IN_RANGE(SETUP_CYC) && `DMGPLUS_CYC_IN_RANGE(ACCESS_CYC) &&
          `DMGPLUS_CYC_IN_RANGE(HOLD_CYC))) begin : g_bad_param
      $error("dmgplus_cart_rd: SETUP_CYC, ACCESS_CYC and HOLD_CYC must each be 1..15");
    end
  endgenerate

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] ACCESS_LD = 4'(ACCESS_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  cart_rd_state_t state_reg, state_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic [15:0]    cart_a_reg, cart_a_next;
  logic [7:0]     rom_data_reg, rom_data_next;
  logic           cart_rd_n_reg, cart_rd_n_next;
  logic           cart_cs_n_reg, cart_cs_n_next;

  always_ff @(posedge clk_8m) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      cart_a_reg    <= 16'h0000;
      rom_data_reg  <= 8'h00;
      cart_rd_n_reg <= 1'b1;
      cart_cs_n_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cart_a_reg    <= cart_a_next;
      rom_data_reg  <= rom_data_next;
      cart_rd_n_reg <= cart_rd_n_next;
      cart_cs_n_reg <= cart_cs_n_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    cart_a_next   = cart_a_reg;
    rom_data_next = rom_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (rom.rom_rd) begin
          cart_a_next = rom.rom_addr;
          cnt_next    = SETUP_LD;
          state_next  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_reg == 4'd0) begin
          cnt_next   = ACCESS_LD;
          state_next = ST_STROBE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_reg == 4'd0) begin
          rom_data_next = cart_d;
          cnt_next      = HOLD_LD;
          state_next    = ST_HOLD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Pin strobes are decoded from the next state so the pins themselves are flops.
    cart_rd_n_next = (state_next != ST_STROBE);
    cart_cs_n_next = !((state_next == ST_STROBE) && cart_cs_range(cart_a_next));
  end

  // Busy in the request cycle itself so a registered requester never sees a stale idle.
  assign rom.rom_bsy  = rom.rom_rd | (state_reg != ST_IDLE);
  assign rom.rom_data = rom_data_reg;

  assign cart_a    = cart_a_reg;
  assign cart_rd_n = cart_rd_n_reg;
  assign cart_cs_n = cart_cs_n_reg;
  assign cart_wr_n = 1'b1;

endmodule
